// File: rtl/pipeline_pkg.sv
// Shared ID-stage forwarding encodings.
// The operand mux and the forwarding unit both use these select codes.
package pipeline_pkg;

  // 2-bit forwarding select as driven by the forwarding unit.
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_NONE    = 2'b00;  // register-file read data
  localparam fwd_sel_t FWD_WB      = 2'b01;  // write-back stage value
  localparam fwd_sel_t FWD_MEM     = 2'b10;  // MEM stage value
  localparam fwd_sel_t FWD_ILLEGAL = 2'b11;  // never produced by a correct unit

  // Maps the illegal-select fallback index onto a legal select code.
  // An out-of-range index falls back to the register-file operand.
  function automatic fwd_sel_t fallback_sel(input int idx);
    fwd_sel_t sel;
    case (idx)
      1:       sel = FWD_WB;
      2:       sel = FWD_MEM;
      default: sel = FWD_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mux_sel_reg.sv
// Registered side-path of the forwarding mux: a one-cycle copy of the
// selected operand and a sticky flag recording any illegal select.
module mux_sel_reg
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_illegal,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_data_reg,
  output logic             o_sticky
);

  logic [WIDTH-1:0] r_data;
  logic             r_sticky;

  // Capture the selected operand every rising edge.
  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values;
  // both flops also reset asynchronously so debug state is known before the first clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
    end else begin
      r_data <= i_data;
    end
  end

  // Sticky illegal flag: a set in the same cycle as a clear wins.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sticky <= 1'b0;
    end else if (i_illegal) begin
      r_sticky <= 1'b1;
    end else if (i_clear) begin
      r_sticky <= 1'b0;
    end
  end

  assign o_data_reg = r_data;
  assign o_sticky   = r_sticky;

endmodule

// File: rtl/mux_3_to_1_32.sv
// ID-stage operand forwarding mux ahead of the branch equality compare.
// The selected value is combinational so the branch resolves this cycle;
// a registered copy and a sticky illegal-select flag sit on a side path.
module mux_3_to_1_32
  import pipeline_pkg::*;
#(
  parameter int WIDTH               = 32,
  parameter int ILLEGAL_SEL_DEFAULT = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] Input_0,
  input  logic [WIDTH-1:0] Input_1,
  input  logic [WIDTH-1:0] Input_2,
  input  logic [1:0]       Control,
  input  logic             Clear_illegal,
  output logic [WIDTH-1:0] Output,
  output logic [WIDTH-1:0] Output_reg,
  output logic             Illegal,
  output logic             Illegal_sticky
);

  localparam fwd_sel_t FALLBACK_SEL = fallback_sel(ILLEGAL_SEL_DEFAULT);

  fwd_sel_t         w_ctrl;
  logic [WIDTH-1:0] w_fallback;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_illegal;

  assign w_ctrl = fwd_sel_t'(Control);

  // Operand routed when the select is 11 (or unknown in synthesis).
  always_comb begin
    w_fallback = Input_0;
    case (FALLBACK_SEL)
      FWD_WB:  w_fallback = Input_1;
      FWD_MEM: w_fallback = Input_2;
      default: w_fallback = Input_0;
    endcase
  end

  // Zero-latency forwarding select.
  // NOTE: the default assignment before the case guarantees no latch is inferred.
  always_comb begin
    w_sel_data = w_fallback;
    case (w_ctrl)
      FWD_NONE: w_sel_data = Input_0;
      FWD_WB:   w_sel_data = Input_1;
      FWD_MEM:  w_sel_data = Input_2;
      default:  w_sel_data = w_fallback;
    endcase
  end

  assign w_illegal = (w_ctrl == FWD_ILLEGAL);

  assign Output  = w_sel_data;
  assign Illegal = w_illegal;

  mux_sel_reg #(
    .WIDTH (WIDTH)
  ) u_sel_reg (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_data     (w_sel_data),
    .i_illegal  (w_illegal),
    .i_clear    (Clear_illegal),
    .o_data_reg (Output_reg),
    .o_sticky   (Illegal_sticky)
  );

endmodule

// File: tb/tb_mux_3_to_1_32.sv
// Self-checking bench for mux_3_to_1_32: expected registered values are
// queued when the select is driven and compared after the next rising edge.
module tb_mux_3_to_1_32;

  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] Input_0, Input_1, Input_2;
  logic [1:0]       Control;
  logic             Clear_illegal;
  logic [WIDTH-1:0] Output, Output_reg;
  logic             Illegal, Illegal_sticky;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_reg;

  mux_3_to_1_32 #(.WIDTH(WIDTH), .ILLEGAL_SEL_DEFAULT(0)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .Input_0        (Input_0),
    .Input_1        (Input_1),
    .Input_2        (Input_2),
    .Control        (Control),
    .Clear_illegal  (Clear_illegal),
    .Output         (Output),
    .Output_reg     (Output_reg),
    .Illegal        (Illegal),
    .Illegal_sticky (Illegal_sticky)
  );

  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL timeout: run did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Pops the oldest expected registered value; an empty queue counts as a miss.
  task automatic pop_expected(output logic [WIDTH-1:0] v);
    if (exp_q.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL scoreboard_empty: no expected value queued");
      v = 'x;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    Input_0 = 32'h1111_1111;
    Input_1 = 32'h2222_2222;
    Input_2 = 32'h3333_3333;
    Control = 2'b01;
    Clear_illegal = 1'b0;
    #1;
    n_compared++;
    if (Output !== 32'h2222_2222) begin
      n_mismatched++;
      $display("FAIL reset_output: got %h want %h", Output, 32'h2222_2222);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      n_compared++;
      if (Output_reg !== '0) begin
        n_mismatched++;
        $display("FAIL reset_output_reg: got %h want 0", Output_reg);
      end
      n_compared++;
      if (Illegal_sticky !== 1'b0) begin
        n_mismatched++;
        $display("FAIL reset_sticky: got %b want 0", Illegal_sticky);
      end
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_select_sweep();
    logic [WIDTH-1:0] exp_out [3];
    exp_out[0] = 32'h1111_1111;
    exp_out[1] = 32'h2222_2222;
    exp_out[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      Control = 2'(i);
      #1;
      n_compared++;
      if (Output !== exp_out[i]) begin
        n_mismatched++;
        $display("FAIL sweep_output sel=%0d: got %h want %h", i, Output, exp_out[i]);
      end
      n_compared++;
      if (Illegal !== 1'b0) begin
        n_mismatched++;
        $display("FAIL sweep_illegal sel=%0d: got %b want 0", i, Illegal);
      end
      exp_q.push_back(exp_out[i]);
      @(posedge clock); #1;
      pop_expected(exp_reg);
      n_compared++;
      if (Output_reg !== exp_reg) begin
        n_mismatched++;
        $display("FAIL sweep_output_reg sel=%0d: got %h want %h", i, Output_reg, exp_reg);
      end
    end
  endtask

  task automatic test_illegal();
    @(negedge clock);
    Control = 2'b11;
    #1;
    n_compared++;
    if (Output !== 32'h1111_1111) begin
      n_mismatched++;
      $display("FAIL illegal_output: got %h want %h", Output, 32'h1111_1111);
    end
    n_compared++;
    if (Illegal !== 1'b1) begin
      n_mismatched++;
      $display("FAIL illegal_flag: got %b want 1", Illegal);
    end
    exp_q.push_back(32'h1111_1111);
    @(posedge clock); #1;
    pop_expected(exp_reg);
    n_compared++;
    if (Output_reg !== exp_reg) begin
      n_mismatched++;
      $display("FAIL illegal_output_reg: got %h want %h", Output_reg, exp_reg);
    end
    n_compared++;
    if (Illegal_sticky !== 1'b1) begin
      n_mismatched++;
      $display("FAIL illegal_sticky_set: got %b want 1", Illegal_sticky);
    end
    @(negedge clock);
    Control = 2'b00;
    @(posedge clock); #1;
    n_compared++;
    if (Illegal_sticky !== 1'b1) begin
      n_mismatched++;
      $display("FAIL illegal_sticky_hold: got %b want 1", Illegal_sticky);
    end
    @(negedge clock);
    Clear_illegal = 1'b1;
    @(posedge clock); #1;
    n_compared++;
    if (Illegal_sticky !== 1'b0) begin
      n_mismatched++;
      $display("FAIL illegal_sticky_clear: got %b want 0", Illegal_sticky);
    end
    @(negedge clock);
    Clear_illegal = 1'b0;
  endtask

  task automatic test_collision();
    @(negedge clock);
    Control = 2'b11;
    Clear_illegal = 1'b1;
    @(posedge clock); #1;
    n_compared++;
    if (Illegal_sticky !== 1'b1) begin
      n_mismatched++;
      $display("FAIL collision_sticky: got %b want 1", Illegal_sticky);
    end
    @(negedge clock);
    Control = 2'b00;
    @(posedge clock); #1;
    n_compared++;
    if (Illegal_sticky !== 1'b0) begin
      n_mismatched++;
      $display("FAIL collision_clear_after: got %b want 0", Illegal_sticky);
    end
    @(negedge clock);
    Clear_illegal = 1'b0;
  endtask

  task automatic test_mid_cycle();
    @(negedge clock);
    Control = 2'b10;
    Input_2 = 32'hDEAD_BEEF;
    #1;
    n_compared++;
    if (Output !== 32'hDEAD_BEEF) begin
      n_mismatched++;
      $display("FAIL mid_output_first: got %h want %h", Output, 32'hDEAD_BEEF);
    end
    exp_q.push_back(32'hDEAD_BEEF);
    @(posedge clock); #1;
    pop_expected(exp_reg);
    n_compared++;
    if (Output_reg !== exp_reg) begin
      n_mismatched++;
      $display("FAIL mid_output_reg_first: got %h want %h", Output_reg, exp_reg);
    end
    #2;
    Input_2 = 32'h0000_FFFF;
    #1;
    n_compared++;
    if (Output !== 32'h0000_FFFF) begin
      n_mismatched++;
      $display("FAIL mid_output_track: got %h want %h", Output, 32'h0000_FFFF);
    end
    n_compared++;
    if (Output_reg !== 32'hDEAD_BEEF) begin
      n_mismatched++;
      $display("FAIL mid_output_reg_early: got %h want %h", Output_reg, 32'hDEAD_BEEF);
    end
    exp_q.push_back(32'h0000_FFFF);
    @(posedge clock); #1;
    pop_expected(exp_reg);
    n_compared++;
    if (Output_reg !== exp_reg) begin
      n_mismatched++;
      $display("FAIL mid_output_reg_after: got %h want %h", Output_reg, exp_reg);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    Input_2 = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    @(posedge clock); #1;
    pop_expected(exp_reg);
    n_compared++;
    if (Output_reg !== exp_reg) begin
      n_mismatched++;
      $display("FAIL async_pre_output_reg: got %h want %h", Output_reg, exp_reg);
    end
    #1;
    reset_n = 1'b0;
    #1;
    n_compared++;
    if (Output_reg !== '0) begin
      n_mismatched++;
      $display("FAIL async_output_reg: got %h want 0", Output_reg);
    end
    n_compared++;
    if (Output !== 32'hDEAD_BEEF) begin
      n_mismatched++;
      $display("FAIL async_output: got %h want %h", Output, 32'hDEAD_BEEF);
    end
    @(negedge clock);
    reset_n = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    @(posedge clock); #1;
    pop_expected(exp_reg);
    n_compared++;
    if (Output_reg !== exp_reg) begin
      n_mismatched++;
      $display("FAIL async_resume_output_reg: got %h want %h", Output_reg, exp_reg);
    end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_illegal();
    test_collision();
    test_mid_cycle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
